// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: two-port round-robin arbiter in front of a 1W/1R memory macro, with per-port read response buffers
module mem_port_arbiter #(
    parameter int ADDR_W = 25,
    parameter int DATA_W = 64,
    parameter int MASK_W = DATA_W / 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              p0_req_valid,
    output logic              p0_req_ready,
    input  logic              p0_req_we,
    input  logic [ADDR_W-1:0] p0_req_addr,
    input  logic [DATA_W-1:0] p0_req_data,
    input  logic [MASK_W-1:0] p0_req_mask,
    output logic              p0_resp_valid,
    input  logic              p0_resp_ready,
    output logic [DATA_W-1:0] p0_resp_data,
    input  logic              p1_req_valid,
    output logic              p1_req_ready,
    input  logic              p1_req_we,
    input  logic [ADDR_W-1:0] p1_req_addr,
    input  logic [DATA_W-1:0] p1_req_data,
    input  logic [MASK_W-1:0] p1_req_mask,
    output logic              p1_resp_valid,
    input  logic              p1_resp_ready,
    output logic [DATA_W-1:0] p1_resp_data,
    output logic [ADDR_W-1:0] W0_addr,
    output logic              W0_en,
    output logic [DATA_W-1:0] W0_data,
    output logic [MASK_W-1:0] W0_mask,
    output logic [ADDR_W-1:0] R0_addr,
    output logic              R0_en,
    input  logic [DATA_W-1:0] R0_data
);
    logic              rr_ptr_q, rr_ptr_d;
    logic [1:0]        rd_pend_q, rd_pend_d;
    logic [1:0]        resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0] resp_data0_q, resp_data0_d;
    logic [DATA_W-1:0] resp_data1_q, resp_data1_d;
    logic              elig0, elig1, gnt0, gnt1, gnt_we;
    logic [ADDR_W-1:0] gnt_addr;

    // A read is eligible only if its buffer is empty or drains this very cycle
    always_comb begin
        elig0 = p0_req_valid & (p0_req_we | (~rd_pend_q[0] & (~resp_valid_q[0] | p0_resp_ready)));
        elig1 = p1_req_valid & (p1_req_we | (~rd_pend_q[1] & (~resp_valid_q[1] | p1_resp_ready)));
        gnt0 = ~reset & elig0 & (~elig1 | rr_ptr_q);
        gnt1 = ~reset & elig1 & (~elig0 | ~rr_ptr_q);
        gnt_we = gnt0 ? p0_req_we : p1_req_we;
        gnt_addr = gnt0 ? p0_req_addr : p1_req_addr;
        W0_en = (gnt0 | gnt1) & gnt_we;
        R0_en = (gnt0 | gnt1) & ~gnt_we;
        W0_addr = W0_en ? gnt_addr : '0;
        W0_data = W0_en ? (gnt0 ? p0_req_data : p1_req_data) : '0;
        W0_mask = W0_en ? (gnt0 ? p0_req_mask : p1_req_mask) : '0;
        R0_addr = R0_en ? gnt_addr : '0;
        rr_ptr_d = gnt1 ? 1'b1 : gnt0 ? 1'b0 : rr_ptr_q;
        rd_pend_d = {gnt1 & ~p1_req_we, gnt0 & ~p0_req_we};
        resp_valid_d[0] = rd_pend_q[0] | (resp_valid_q[0] & ~p0_resp_ready);
        resp_valid_d[1] = rd_pend_q[1] | (resp_valid_q[1] & ~p1_resp_ready);
        resp_data0_d = rd_pend_q[0] ? R0_data : resp_data0_q;
        resp_data1_d = rd_pend_q[1] ? R0_data : resp_data1_q;
        p0_req_ready = gnt0;
        p1_req_ready = gnt1;
        p0_resp_valid = resp_valid_q[0];
        p1_resp_valid = resp_valid_q[1];
        p0_resp_data = resp_data0_q;
        p1_resp_data = resp_data1_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr_q     <= 1'b0;
            rd_pend_q    <= '0;
            resp_valid_q <= '0;
            resp_data0_q <= '0;
            resp_data1_q <= '0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            rd_pend_q    <= rd_pend_d;
            resp_valid_q <= resp_valid_d;
            resp_data0_q <= resp_data0_d;
            resp_data1_q <= resp_data1_d;
        end
    end
endmodule
